sigmoid_series_eval: RTL and testbench

Sequential, parametrised sigmoid evaluator for the neural-network datapath. It splits |x| into unit-width segments and evaluates a per-segment Maclaurin-style polynomial in d = |x| - segment_base by Horner's rule, using one multiply per cycle. The NSEG x NTERMS coefficient table is host-programmable rather than hard-wired. Negative inputs use sigmoid(-x) = 1 - sigmoid(x). Input and output use valid/ready handshakes.

---
 rtl/sigmoid_series_eval.sv | 200 ++++++++++++++++++++
 tb/tb_sigmoid_series_eval.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_series_eval.sv
// Sequential sigmoid evaluator: per-segment Horner polynomial in d = |x| - seg,
// one multiply per cycle, host-programmable coefficient table, valid/ready I/O.
module sigmoid_series_eval #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int NSEG   = 6,
    parameter int NTERMS = 3,
    parameter int SEGW   = 3,
    parameter int TERMW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_y,
    input  logic              cfg_we,
    input  logic [SEGW-1:0]   cfg_seg,
    input  logic [TERMW-1:0]  cfg_term,
    input  logic [DWIDTH-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              busy
);

    localparam logic signed [DWIDTH-1:0] ONE    = DWIDTH'(1) << FRAC;
    localparam logic signed [DWIDTH-1:0] MAXV   = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] MINV   = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [SEGW-1:0]          SEGSAT = SEGW'(NSEG - 1);
    localparam logic [TERMW-1:0]         KTOP   = TERMW'(NTERMS - 2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_FOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                     state_r;
    logic signed [DWIDTH-1:0]   coef_r [NSEG][NTERMS];
    logic                       neg_r;
    logic [SEGW-1:0]            seg_r;
    logic signed [DWIDTH-1:0]   d_r;
    logic signed [DWIDTH-1:0]   acc_r;
    logic [TERMW-1:0]           k_r;
    logic                       in_ready_r;
    logic                       out_valid_r;
    logic [DWIDTH-1:0]          out_y_r;
    logic                       cfg_ready_r;
    logic                       busy_r;

    logic                       accept_s;
    logic                       cfg_ok_s;
    logic signed [DWIDTH-1:0]   ax_s;
    logic [DWIDTH-1:0]          segq_s;
    logic [SEGW-1:0]            seg_s;
    logic signed [DWIDTH-1:0]   d_s;
    logic signed [2*DWIDTH-1:0] prod_s;
    logic signed [2*DWIDTH-1:0] shr_s;
    logic signed [DWIDTH-1:0]   coef_k_s;
    logic signed [DWIDTH-1:0]   mac_s;
    logic signed [DWIDTH-1:0]   fold_s;

    // Clamp a DWIDTH+1 bit sum back into the signed DWIDTH range.
    function automatic logic signed [DWIDTH-1:0] sat(input logic signed [DWIDTH:0] v);
        if (v[DWIDTH] != v[DWIDTH-1]) begin
            return v[DWIDTH] ? MINV : MAXV;
        end else begin
            return v[DWIDTH-1:0];
        end
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_y     = out_y_r;
    assign cfg_ready = cfg_ready_r;
    assign busy      = busy_r;

    // Handshake qualifiers and segment decode of the incoming sample.
    always_comb begin
        accept_s = in_valid & in_ready_r;
        cfg_ok_s = cfg_we & cfg_ready_r &
                   (32'(cfg_seg) < NSEG) & (32'(cfg_term) < NTERMS);
        if (in_x[DWIDTH-1]) begin
            if ($signed(in_x) == MINV) begin
                ax_s = MAXV;
            end else begin
                ax_s = -$signed(in_x);
            end
        end else begin
            ax_s = $signed(in_x);
        end
        segq_s = ax_s >> FRAC;
        if (segq_s >= DWIDTH'(NSEG - 1)) begin
            seg_s = SEGSAT;
        end else begin
            seg_s = segq_s[SEGW-1:0];
        end
        d_s = ax_s - ({{(DWIDTH-SEGW){1'b0}}, seg_s} << FRAC);
    end

    // One Horner step and the sign fold for negative inputs.
    always_comb begin
        prod_s   = acc_r * d_r;
        shr_s    = prod_s >>> FRAC;
        coef_k_s = coef_r[seg_r][k_r];
        mac_s    = sat({shr_s[DWIDTH-1], shr_s[DWIDTH-1:0]} + {coef_k_s[DWIDTH-1], coef_k_s});
        if (neg_r) begin
            fold_s = sat({1'b0, ONE} - {acc_r[DWIDTH-1], acc_r});
        end else begin
            fold_s = acc_r;
        end
    end

    // Coefficient table; writes only land while idle and in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NSEG; s++) begin
                for (int t = 0; t < NTERMS; t++) begin
                    coef_r[s][t] <= {DWIDTH{1'b0}};
                end
            end
        end else if (cfg_ok_s) begin
            coef_r[cfg_seg][cfg_term] <= cfg_data;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            neg_r       <= 1'b0;
            seg_r       <= {SEGW{1'b0}};
            d_r         <= {DWIDTH{1'b0}};
            acc_r       <= {DWIDTH{1'b0}};
            k_r         <= {TERMW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_y_r     <= {DWIDTH{1'b0}};
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        neg_r       <= in_x[DWIDTH-1];
                        seg_r       <= seg_s;
                        d_r         <= d_s;
                        in_ready_r  <= 1'b0;
                        cfg_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (seg_r == SEGSAT) begin
                        acc_r   <= ONE;
                        state_r <= S_FOLD;
                    end else begin
                        acc_r   <= coef_r[seg_r][NTERMS-1];
                        k_r     <= KTOP;
                        state_r <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_r <= mac_s;
                    if (k_r == {TERMW{1'b0}}) begin
                        state_r <= S_FOLD;
                    end else begin
                        k_r <= k_r - TERMW'(1);
                    end
                end
                S_FOLD: begin
                    out_y_r     <= fold_s;
                    out_valid_r <= 1'b1;
                    state_r     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        cfg_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    cfg_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_series_eval.sv
// Self-checking bench for sigmoid_series_eval: directed scenarios plus randomized
// coefficients/inputs against an integer-arithmetic reference model.
module tb_sigmoid_series_eval;

    localparam int     NSEG = 6;
    localparam int     NT   = 3;
    localparam int     FRAC = 24;
    localparam longint ONE  = longint'(1) << FRAC;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_y;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_seg = 3'd0;
    logic [1:0]  cfg_term = 2'd0;
    logic [31:0] cfg_data = 32'h0;
    logic        cfg_ready;
    logic        busy;

    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    longint mcoef [NSEG][NT];

    sigmoid_series_eval dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .cfg_we(cfg_we), .cfg_seg(cfg_seg), .cfg_term(cfg_term), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint clamp(input longint v);
        if (v > MAXV) return MAXV;
        else if (v < MINV) return MINV;
        else return v;
    endfunction

    function automatic longint abs_of(input logic [31:0] x);
        longint a;
        a = longint'($signed(x));
        if (a < 0) a = -a;
        if (a > MAXV) a = MAXV;
        return a;
    endfunction

    function automatic int seg_of(input logic [31:0] x);
        longint s;
        s = abs_of(x) / ONE;
        if (s > NSEG - 1) s = NSEG - 1;
        return int'(s);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] x);
        longint d, acc, p;
        int     s, t;
        s = seg_of(x);
        d = abs_of(x) - longint'(s) * ONE;
        if (s == NSEG - 1) begin
            acc = ONE;
        end else begin
            acc = mcoef[s][NT-1];
            for (int k = NT - 2; k >= 0; k--) begin
                p   = (acc * d) >>> FRAC;
                t   = p[31:0];
                acc = clamp(longint'(t) + mcoef[s][k]);
            end
        end
        if (x[31]) acc = clamp(ONE - acc);
        return acc[31:0];
    endfunction

    task automatic cfg_write(input int s, input int t, input logic [31:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_seg = 3'(s); cfg_term = 2'(t); cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        if (s < NSEG && t < NT) mcoef[s][t] = longint'($signed(data));
    endtask

    task automatic start(input logic [31:0] x, input bit wr, input int ws, input int wt,
                         input logic [31:0] wd, output int t0);
        @(negedge clk);
        in_valid = 1'b1; in_x = x;
        if (wr) begin
            cfg_we = 1'b1; cfg_seg = 3'(ws); cfg_term = 2'(wt); cfg_data = wd;
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0; t0 = cyc;
        if (wr && ws < NSEG && wt < NT) mcoef[ws][wt] = longint'($signed(wd));
    endtask

    task automatic wait_out(input int t0, output int lat, output logic [31:0] y);
        while (out_valid !== 1'b1 && (cyc - t0) < 40) @(negedge clk);
        lat = cyc - t0 + 1;
        y   = out_y;
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic eval(input logic [31:0] x, input int hold, output logic [31:0] y, output int lat);
        int t0;
        start(x, 1'b0, 0, 0, 32'h0, t0);
        wait_out(t0, lat, y);
        repeat (hold) @(negedge clk);
        release_out();
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_y !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b y=%h ir=%b busy=%b cr=%b expected 0 0 1 0 1",
                     out_valid, out_y, in_ready, busy, cfg_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle: got v=%b ir=%b busy=%b cr=%b", out_valid, in_ready, busy, cfg_ready);
        end
    endtask

    task automatic test_series;
        logic [31:0] y;
        int t0, lat;
        cfg_write(0, 0, 32'h00800000);
        cfg_write(0, 1, 32'h00400000);
        cfg_write(0, 2, 32'h00000000);
        start(32'h00800000, 1'b0, 0, 0, 32'h0, t0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_flags: got ir=%b busy=%b cr=%b expected 0 1 0", in_ready, busy, cfg_ready);
        end
        wait_out(t0, lat, y);
        release_out();
        checks++;
        if (y !== 32'h00A00000 || lat !== 5) begin
            failures++;
            $display("FAIL pos_half: got y=%h lat=%0d expected y=00a00000 lat=5", y, lat);
        end
        eval(32'hFF800000, 0, y, lat);
        checks++;
        if (y !== 32'h00600000 || lat !== 5) begin
            failures++;
            $display("FAIL neg_half: got y=%h lat=%0d expected y=00600000 lat=5", y, lat);
        end
        eval(32'h00000000, 1, y, lat);
        checks++;
        if (y !== 32'h00800000) begin
            failures++;
            $display("FAIL zero_in: got %h expected 00800000", y);
        end
    endtask

    task automatic test_saturation;
        logic [31:0] y;
        int lat;
        logic [31:0] xs [5] = '{32'h07000000, 32'hF9000000, 32'h80000000, 32'h05000000, 32'h04FFFFFF};
        logic [31:0] ys [5] = '{32'h01000000, 32'h00000000, 32'h00000000, 32'h01000000, 32'h00000000};
        int          ls [5] = '{3, 3, 3, 3, 5};
        for (int i = 0; i < 5; i++) begin
            eval(xs[i], 0, y, lat);
            checks++;
            if (y !== ys[i] || lat !== ls[i]) begin
                failures++;
                $display("FAIL saturation_%0d: x=%h got y=%h lat=%0d expected y=%h lat=%0d",
                         i, xs[i], y, lat, ys[i], ls[i]);
            end
        end
    endtask

    task automatic test_busy_write;
        logic [31:0] y;
        int t0, lat;
        cfg_write(1, 0, 32'h00D14000);
        cfg_write(1, 1, 32'h00000000);
        cfg_write(1, 2, 32'h00000000);
        eval(32'h01400000, 0, y, lat);
        checks++;
        if (y !== 32'h00D14000) begin
            failures++;
            $display("FAIL seg1_eval: got %h expected 00d14000", y);
        end
        start(32'h01400000, 1'b0, 0, 0, 32'h0, t0);
        cfg_we = 1'b1; cfg_seg = 3'd1; cfg_term = 2'd0; cfg_data = 32'h12345678;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_out(t0, lat, y);
        release_out();
        checks++;
        if (y !== 32'h00D14000) begin
            failures++;
            $display("FAIL busy_write_inflight: got %h expected 00d14000", y);
        end
        eval(32'h01400000, 0, y, lat);
        checks++;
        if (y !== 32'h00D14000) begin
            failures++;
            $display("FAIL busy_write_dropped: got %h expected 00d14000", y);
        end
        cfg_write(0, 3, 32'h7FFFFFFF);
        cfg_write(6, 0, 32'h7FFFFFFF);
        cfg_write(7, 2, 32'h7FFFFFFF);
        eval(32'h00800000, 0, y, lat);
        checks++;
        if (y !== 32'h00A00000) begin
            failures++;
            $display("FAIL out_of_range_write: got %h expected 00a00000", y);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] y;
        int t0, lat, bad;
        start(32'h00800000, 1'b0, 0, 0, 32'h0, t0);
        wait_out(t0, lat, y);
        checks++;
        if (y !== 32'h00A00000 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_first: got y=%h v=%b expected 00a00000 1", y, out_valid);
        end
        in_valid = 1'b1; in_x = 32'h03000000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_y !== y || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got v=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_single_handshake: got %0d stray cycles expected 0", bad);
        end
    endtask

    task automatic test_write_on_accept;
        logic [31:0] y;
        int t0, lat;
        start(32'h00800000, 1'b1, 0, 2, 32'h00400000, t0);
        wait_out(t0, lat, y);
        release_out();
        checks++;
        if (y !== 32'h00B00000 || lat !== 5) begin
            failures++;
            $display("FAIL write_on_accept: got y=%h lat=%0d expected y=00b00000 lat=5", y, lat);
        end
    endtask

    task automatic test_random;
        logic [31:0] x, y, exp_y, data;
        int lat, exp_lat, nw;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                nw = $urandom_range(1, 3);
                for (int w = 0; w < nw; w++) begin
                    if ($urandom_range(0, 7) == 0) data = $urandom;
                    else data = 32'($urandom_range(0, 32'h04000000)) - 32'h02000000;
                    cfg_write($urandom_range(0, 7), $urandom_range(0, 3), data);
                end
            end
            case ($urandom_range(0, 3))
                0: x = $urandom;
                1: x = 32'($urandom_range(0, 32'h06FFFFFF));
                2: x = 32'h0 - 32'($urandom_range(0, 32'h06FFFFFF));
                default: x = 32'($urandom_range(0, 5)) << FRAC;
            endcase
            exp_y   = model(x);
            exp_lat = (seg_of(x) == NSEG - 1) ? 3 : 5;
            eval(x, $urandom_range(0, 3), y, lat);
            checks++;
            if (y !== exp_y || lat !== exp_lat) begin
                failures++;
                $display("FAIL random_%0d: x=%h got y=%h lat=%0d expected y=%h lat=%0d",
                         it, x, y, lat, exp_y, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] y;
        int t0, lat, bad;
        start(32'h00800000, 1'b0, 0, 0, 32'h0, t0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: got ir=%b v=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < NSEG; s++)
            for (int t = 0; t < NT; t++) mcoef[s][t] = 0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_output: got %0d valid cycles expected 0", bad);
        end
        eval(32'h00800000, 0, y, lat);
        checks++;
        if (y !== 32'h00000000 || y !== model(32'h00800000)) begin
            failures++;
            $display("FAIL reset_mid_table_cleared: got %h expected 00000000", y);
        end
    endtask

    initial begin
        for (int s = 0; s < NSEG; s++)
            for (int t = 0; t < NT; t++) mcoef[s][t] = 0;
        test_reset();
        test_series();
        test_saturation();
        test_busy_write();
        test_backpressure();
        test_write_on_accept();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
